// File: rtl/mmm_stream_tx.sv
// mmm_stream_tx: streams A (optional) then B from the source RAM over AXI-Stream,
// one burst per host command, through a 2-entry skid buffer with a bypass path.
module mmm_stream_tx #(
    parameter int INW  = 12,
    parameter int M    = 7,
    parameter int N    = 9,
    parameter int MAXK = 8,
    localparam int K_BITS = $clog2(MAXK + 1),
    localparam int SRC_AW = $clog2(M * MAXK + MAXK * N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [K_BITS-1:0] cmd_k,
    input  logic              cmd_new_a,
    output logic              src_rd_en,
    output logic [SRC_AW-1:0] src_rd_addr,
    input  logic [INW-1:0]    src_rd_data,
    output logic [INW-1:0]    AXIS_TDATA,
    output logic              AXIS_TVALID,
    output logic [K_BITS:0]   AXIS_TUSER,
    input  logic              AXIS_TREADY,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, FINISH} state_t;
    state_t state_q, state_d;
    logic [K_BITS-1:0] k_q, k_d;
    logic new_a_q, new_a_d, bad_q, bad_d, rd_last_q, rd_last_d, inflight_q, inflight_d;
    logic [SRC_AW-1:0] idx_q, idx_d, phase_last;
    logic [1:0] occ_q, occ_d, total;
    logic rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [INW-1:0] buf_q [2];
    logic [INW-1:0] buf_d [2];
    logic hs, wr, pop, last;

    always_comb begin
        total       = occ_q + {1'b0, inflight_q};
        AXIS_TVALID = total != 2'd0;
        // Data returning this cycle goes straight out when nothing is buffered ahead of it.
        AXIS_TDATA  = occ_q != 2'd0 ? buf_q[rd_ptr_q] : src_rd_data;
        AXIS_TUSER  = {k_q, new_a_q};
        hs          = AXIS_TVALID && AXIS_TREADY;
        pop         = hs && occ_q != 2'd0;
        wr          = inflight_q && !(hs && occ_q == 2'd0);
        phase_last  = SRC_AW'((state_q == SEND_A ? M : N) * int'(k_q) - 1);
        last        = idx_q == phase_last;
        src_rd_en   = (state_q == SEND_A || (state_q == SEND_B && !rd_last_q))
                      && (total < 2'd2 || (total == 2'd2 && hs));
        src_rd_addr = state_q == SEND_A ? idx_q : SRC_AW'(M * MAXK) + idx_q;
        cmd_ready   = state_q == IDLE;
        done        = state_q == FINISH;
        err         = done && bad_q;
        state_d     = state_q;
        k_d         = k_q;
        new_a_d     = new_a_q;
        bad_d       = bad_q;
        idx_d       = idx_q;
        rd_last_d   = rd_last_q;
        inflight_d  = src_rd_en;
        occ_d       = occ_q + {1'b0, wr} - {1'b0, pop};
        rd_ptr_d    = rd_ptr_q ^ pop;
        wr_ptr_d    = wr_ptr_q ^ wr;
        buf_d       = buf_q;
        if (wr) buf_d[wr_ptr_q] = src_rd_data;
        if (state_q == IDLE && cmd_valid) begin
            k_d       = cmd_k;
            new_a_d   = cmd_new_a;
            bad_d     = cmd_k == '0 || cmd_k > K_BITS'(MAXK);
            idx_d     = '0;
            rd_last_d = 1'b0;
            state_d   = bad_d ? FINISH : (cmd_new_a ? SEND_A : SEND_B);
        end
        // The index stops on the final B address so the address never runs past the phase.
        if (src_rd_en && last && state_q == SEND_A) begin
            state_d = SEND_B;
            idx_d   = '0;
        end else if (src_rd_en && last) rd_last_d = 1'b1;
        else if (src_rd_en) idx_d = idx_q + 1'b1;
        if (state_q == SEND_B && rd_last_q && hs && total == 2'd1) state_d = FINISH;
        if (state_q == FINISH) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            new_a_q    <= 1'b0;
            bad_q      <= 1'b0;
            idx_q      <= '0;
            rd_last_q  <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            buf_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            new_a_q    <= new_a_d;
            bad_q      <= bad_d;
            idx_q      <= idx_d;
            rd_last_q  <= rd_last_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            buf_q      <= buf_d;
        end
    end
endmodule

// File: tb/tb_mmm_stream_tx.sv
// tb_mmm_stream_tx: directed scenarios for mmm_stream_tx against a simple
// source RAM whose contents are a known function of the address.
module tb_mmm_stream_tx;
    localparam int INW = 12, M = 7, N = 9, MAXK = 8, KB = 4, AW = 7;
    typedef int iq_t[$];

    logic clk = 0, reset = 1, cmd_valid = 0, cmd_new_a = 0, AXIS_TREADY = 1;
    logic cmd_ready, src_rd_en, AXIS_TVALID, done, err;
    logic [KB-1:0] cmd_k = '0;
    logic [AW-1:0] src_rd_addr;
    logic [INW-1:0] src_rd_data = '0, AXIS_TDATA;
    logic [KB:0] AXIS_TUSER;

    int errors = 0, checks = 0, cyc = 0;
    int beat_d[$], beat_u[$], rd_a[$], acc_q[$], done_q[$], err_q[$];
    int first_tv = -1, first_rd = -1, rdy_cnt = 0, stall_viol = 0;
    logic prev_stall = 0;
    logic [INW-1:0] prev_data;
    logic [KB:0] prev_user;

    mmm_stream_tx dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_k(cmd_k), .cmd_new_a(cmd_new_a), .src_rd_en(src_rd_en),
        .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data), .AXIS_TDATA(AXIS_TDATA),
        .AXIS_TVALID(AXIS_TVALID), .AXIS_TUSER(AXIS_TUSER), .AXIS_TREADY(AXIS_TREADY),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [INW-1:0] f(input int a);
        return INW'(a * 29 + 300);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (src_rd_en) src_rd_data <= f(int'(src_rd_addr));
    end

    initial forever begin
        @(negedge clk);
        if (reset) prev_stall = 0;
        else begin
            if (prev_stall && (!AXIS_TVALID || AXIS_TDATA !== prev_data || AXIS_TUSER !== prev_user))
                stall_viol++;
            prev_stall = AXIS_TVALID && !AXIS_TREADY;
            prev_data  = AXIS_TDATA;
            prev_user  = AXIS_TUSER;
            if (AXIS_TVALID && AXIS_TREADY) begin
                beat_d.push_back(int'(AXIS_TDATA));
                beat_u.push_back(int'(AXIS_TUSER));
            end
            if (AXIS_TVALID && first_tv < 0) first_tv = cyc;
            if (src_rd_en) begin
                rd_a.push_back(int'(src_rd_addr));
                if (first_rd < 0) first_rd = cyc;
            end
            if (cmd_ready) rdy_cnt++;
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
            if (done) done_q.push_back(cyc);
            if (err) err_q.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic iq_t exp_addrs(input int k, input bit a);
        iq_t q;
        if (a) for (int i = 0; i < M * k; i++) q.push_back(i);
        for (int i = 0; i < N * k; i++) q.push_back(M * MAXK + i);
        return q;
    endfunction

    // Number of beats or read addresses that disagree with the expected burst.
    function automatic int stream_bad(input int k, input bit a);
        iq_t e = exp_addrs(k, a);
        int n = int'(beat_d.size() != e.size()) + int'(rd_a.size() != e.size());
        foreach (e[i]) begin
            if (i >= beat_d.size() || beat_d[i] != int'(f(e[i])) || beat_u[i] != k * 2 + int'(a)) n++;
            if (i >= rd_a.size() || rd_a[i] != e[i]) n++;
        end
        return n;
    endfunction

    task automatic clear();
        beat_d.delete(); beat_u.delete(); rd_a.delete();
        acc_q.delete(); done_q.delete(); err_q.delete();
        first_tv = -1; first_rd = -1; rdy_cnt = 0; stall_viol = 0;
    endtask

    task automatic do_cmd(input int k, input bit a);
        @(posedge clk); #1;
        cmd_k = KB'(k); cmd_new_a = a; cmd_valid = 1;
        for (int i = 0; i < 50 && acc_q.size() == 0; i++) begin @(posedge clk); #1; end
        cmd_valid = 0;
        checks++;
        if (acc_q.size() !== 1) begin
            errors++;
            $display("FAIL cmd_accept k=%0d: accepts=%0d required=1", k, acc_q.size());
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && done_q.size() < n; i++) begin @(posedge clk); #1; end
        checks++;
        if (done_q.size() < n) begin
            errors++;
            $display("FAIL done_timeout: done pulses=%0d required=%0d", done_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1; #1;
        checks++;
        if ({cmd_ready, AXIS_TVALID, src_rd_en, done, err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_state: {rdy,tv,rd,done,err}=%b required=10000",
                     {cmd_ready, AXIS_TVALID, src_rd_en, done, err});
        end
        @(negedge clk); reset = 0;
        @(posedge clk); #1;
        checks++;
        if ({cmd_ready, AXIS_TVALID} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset: {rdy,tv}=%b required=10", {cmd_ready, AXIS_TVALID});
        end
    endtask

    task automatic test_basic();
        int a0;
        clear(); do_cmd(2, 1); wait_done(1, 200);
        a0 = acc_q[0];
        checks++;
        if (stream_bad(2, 1) !== 0) begin
            errors++; $display("FAIL basic_stream: beats=%0d bad=%0d required beats=32 bad=0", beat_d.size(), stream_bad(2, 1));
        end
        checks++;
        if (first_rd - a0 !== 1) begin errors++; $display("FAIL basic_first_rd: lat=%0d required=1", first_rd - a0); end
        checks++;
        if (first_tv - a0 !== 2) begin errors++; $display("FAIL basic_first_tvalid: lat=%0d required=2", first_tv - a0); end
        checks++;
        if (done_q[0] - a0 !== 34) begin errors++; $display("FAIL basic_done_time: lat=%0d required=34", done_q[0] - a0); end
        #50;
        checks++;
        if (done_q.size() !== 1 || err_q.size() !== 0) begin
            errors++; $display("FAIL basic_done_once: done=%0d err=%0d required 1/0", done_q.size(), err_q.size());
        end
    endtask

    task automatic test_b_only();
        int low = 0;
        clear(); do_cmd(8, 0); wait_done(1, 300);
        foreach (rd_a[i]) if (rd_a[i] < M * MAXK) low++;
        checks++;
        if (stream_bad(8, 0) !== 0) begin
            errors++; $display("FAIL bonly_stream: beats=%0d bad=%0d required beats=72 bad=0", beat_d.size(), stream_bad(8, 0));
        end
        checks++;
        if (low !== 0) begin errors++; $display("FAIL bonly_a_reads: got=%0d required=0", low); end
        checks++;
        if (done_q[0] - acc_q[0] !== 74) begin errors++; $display("FAIL bonly_done_time: lat=%0d required=74", done_q[0] - acc_q[0]); end
    endtask

    task automatic test_backpressure();
        clear(); do_cmd(3, 1);
        for (int i = 0; i < 3000 && done_q.size() == 0; i++) begin
            @(posedge clk); #1;
            AXIS_TREADY = (i % 37 < 10) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        AXIS_TREADY = 1;
        checks++;
        if (stream_bad(3, 1) !== 0) begin
            errors++; $display("FAIL bp_stream: beats=%0d bad=%0d required beats=48 bad=0", beat_d.size(), stream_bad(3, 1));
        end
        checks++;
        if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable: violations=%0d required=0", stall_viol); end
        checks++;
        if (done_q.size() !== 1) begin errors++; $display("FAIL bp_done: pulses=%0d required=1", done_q.size()); end
    endtask

    task automatic test_illegal();
        int ks[2] = '{0, 9};
        foreach (ks[j]) begin
            clear(); do_cmd(ks[j], 1);
            repeat (4) begin @(posedge clk); #1; end
            checks++;
            if (beat_d.size() !== 0 || rd_a.size() !== 0) begin
                errors++; $display("FAIL illegal_k%0d_traffic: beats=%0d reads=%0d required 0/0", ks[j], beat_d.size(), rd_a.size());
            end
            checks++;
            if (done_q.size() !== 1 || err_q.size() !== 1 || done_q[0] !== acc_q[0] + 1 || err_q[0] !== done_q[0]) begin
                errors++; $display("FAIL illegal_k%0d_pulse: done=%0d err=%0d dlat=%0d required 1/1/1",
                                   ks[j], done_q.size(), err_q.size(), done_q[0] - acc_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear(); do_cmd(2, 1);
        for (int i = 0; i < 100 && beat_d.size() < 20; i++) begin @(posedge clk); #1; end
        @(negedge clk); #2;
        reset = 1; #1;
        checks++;
        if ({AXIS_TVALID, src_rd_en, cmd_ready} !== 3'b001) begin
            errors++; $display("FAIL midreset_async: {tv,rd,rdy}=%b required=001", {AXIS_TVALID, src_rd_en, cmd_ready});
        end
        @(negedge clk); #2; reset = 0;
        clear();
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (beat_d.size() !== 0 || rd_a.size() !== 0) begin
            errors++; $display("FAIL midreset_quiet: beats=%0d reads=%0d required 0/0", beat_d.size(), rd_a.size());
        end
        do_cmd(1, 1); wait_done(1, 100);
        checks++;
        if (stream_bad(1, 1) !== 0) begin
            errors++; $display("FAIL midreset_restart: beats=%0d bad=%0d required beats=16 bad=0", beat_d.size(), stream_bad(1, 1));
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        clear();
        cmd_k = 4'd1; cmd_new_a = 0; cmd_valid = 1;
        for (int i = 0; i < 100 && acc_q.size() < 2; i++) begin @(posedge clk); #1; end
        cmd_valid = 0;
        checks++;
        if (acc_q.size() !== 2 || done_q.size() < 1 || acc_q[1] !== done_q[0] + 1) begin
            errors++; $display("FAIL b2b_second_accept: accepts=%0d gap=%0d required 2/1", acc_q.size(), acc_q[1] - done_q[0]);
        end
        checks++;
        if (rdy_cnt !== 2) begin errors++; $display("FAIL b2b_ready_low: ready cycles=%0d required=2", rdy_cnt); end
        wait_done(2, 100);
        checks++;
        if (beat_d.size() !== 18) begin errors++; $display("FAIL b2b_beats: got=%0d required=18", beat_d.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_b_only();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
